// File: rtl/adder_rr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adder_rr_arbiter_if                                          |
// | Description : Bundle of request and response signals between the compute  |
// |               lanes, the shared-adder arbiter and the result consumer.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Signals
//   req_valid  [N_REQ]        lane i has operands pending
//   req_ready  [N_REQ]        one-hot grant back to the lanes
//   req_a      [N_REQ*WIDTH]  operand a, lane i at [i*WIDTH +: WIDTH]
//   req_b      [N_REQ*WIDTH]  operand b, lane i at [i*WIDTH +: WIDTH]
//   rsp_valid  [1]            result register occupied
//   rsp_ready  [1]            consumer takes the result
//   rsp_id     [ID_W]         lane the result belongs to
//   rsp_sum    [WIDTH]        registered sum
//   grant_cnt  [32]           running count of accepted requests
// Modports
//   master : lanes plus consumer (drive requests and rsp_ready)
//   slave  : the arbiter itself
interface adder_rr_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_sum;
  logic [31:0]            grant_cnt;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, grant_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, grant_cnt
  );
endinterface
`default_nettype wire

// File: rtl/adder_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adder_rr_arbiter                                             |
// | Description : Time-shares one WIDTH-bit adder among N_REQ requesters with  |
// |               round-robin arbitration. The sum lands in a single-entry     |
// |               output register with valid/ready backpressure and carries    |
// |               the id of the requester it belongs to.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of adder_rr_arbiter_if (request lanes, response
//          register, accepted-request counter)
// Parameters
//   WIDTH  operand/sum width; carry out of the adder is discarded
//   N_REQ  number of requesters (>= 2)
module adder_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  adder_rr_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(N_REQ);
  localparam logic [ID_W-1:0] C_LAST_ID = ID_W'(N_REQ - 1);

  // Registered state
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q,   rsp_sum_d;
  logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [31:0]      grant_cnt_q, grant_cnt_d;

  // Arbitration results
  logic             w_found;
  logic [ID_W-1:0]  w_grant_idx;
  logic             w_can_load;
  logic             w_grant;
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;
  logic [WIDTH-1:0] w_sum;

  // The output register can accept a new result when it is empty or is being
  // drained this very cycle; the latter gives one result per cycle.
  assign w_can_load = !rsp_valid_q || bus.rsp_ready;

  // Rotating priority scan starting at rr_ptr. The index wraps by subtraction
  // so non-power-of-two N_REQ works without a modulo operator.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!w_found && bus.req_valid[idx]) begin
        w_found     = 1'b1;
        w_grant_idx = ID_W'(idx);
      end
    end
  end

  // Reset gates the grant so nothing is accepted in a reset cycle.
  assign w_grant = w_found && w_can_load && rst_n;

  // One-hot grant vector.
  always_comb begin
    bus.req_ready = '0;
    if (w_grant) begin
      bus.req_ready[w_grant_idx] = 1'b1;
    end
  end

  // Shared adder: operand mux followed by a single WIDTH-bit add.
  assign w_a_sel = bus.req_a[int'(w_grant_idx)*WIDTH +: WIDTH];
  assign w_b_sel = bus.req_b[int'(w_grant_idx)*WIDTH +: WIDTH];
  assign w_sum   = w_a_sel + w_b_sel;

  // Next-state logic.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rr_ptr_d    = rr_ptr_q;
    grant_cnt_d = grant_cnt_q;

    if (w_grant) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = w_grant_idx;
      rsp_sum_d   = w_sum;
      rr_ptr_d    = (w_grant_idx == C_LAST_ID) ? '0 : w_grant_idx + ID_W'(1);
      grant_cnt_d = grant_cnt_q + 32'd1;
    end else if (bus.rsp_ready) begin
      // Drain without refill: payload holds its last value.
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rr_ptr_q    <= '0;
      grant_cnt_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.grant_cnt = grant_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_adder_rr_arbiter                                          |
// | Description : Directed testbench for adder_rr_arbiter with a queue-based   |
// |               scoreboard; stimulus pushes expected results, a monitor pops |
// |               and compares on every response handshake.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_adder_rr_arbiter;

  localparam int WIDTH = 32;
  localparam int N_REQ = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] sum;
  } exp_t;

  logic clk;
  logic rst_n;

  adder_rr_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus_if ();

  adder_rr_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
    bus_if.req_valid[i]             = v;
    bus_if.req_a[i*WIDTH +: WIDTH]  = a;
    bus_if.req_b[i*WIDTH +: WIDTH]  = b;
  endtask

  // Monitor: every response handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus_if.rsp_valid && bus_if.rsp_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got id=%0d sum=0x%0h expected no response",
                 bus_if.rsp_id, bus_if.rsp_sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus_if.rsp_id !== e.id || bus_if.rsp_sum !== e.sum) begin
          n_err++;
          $display("FAIL rsp_data: got id=%0d sum=0x%0h expected id=%0d sum=0x%0h",
                   bus_if.rsp_id, bus_if.rsp_sum, e.id, e.sum);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  seq_id  [8] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic [31:0] lane_sum[4] = '{32'h1005, 32'h2006, 32'h3007, 32'h4008};
    exp_t dropped;

    rst_n            = 1'b0;
    bus_if.req_valid = '0;
    bus_if.req_a     = '0;
    bus_if.req_b     = '0;
    bus_if.rsp_ready = 1'b1;

    // 1: reset with every lane requesting
    for (int i = 0; i < N_REQ; i++) set_lane(i, 1'b1, 32'd1, 32'd1);
    tick();
    tick();
    chk("reset_req_ready", 64'(bus_if.req_ready), 64'h0);
    chk("reset_rsp_valid", 64'(bus_if.rsp_valid), 64'h0);
    chk("reset_grant_cnt", 64'(bus_if.grant_cnt), 64'h0);
    chk("reset_rsp_sum",   64'(bus_if.rsp_sum),   64'h0);
    bus_if.req_valid = '0;
    rst_n = 1'b1;
    tick();

    // 2: single lane 2, 5 + 7
    set_lane(2, 1'b1, 32'd5, 32'd7);
    #1;
    chk("single_req_ready", 64'(bus_if.req_ready), 64'h4);
    exp_q.push_back('{id: 2'd2, sum: 32'd12});
    tick();
    set_lane(2, 1'b0, 32'd0, 32'd0);
    chk("single_rsp_valid", 64'(bus_if.rsp_valid), 64'h1);
    chk("single_grant_cnt", 64'(bus_if.grant_cnt), 64'd1);
    tick();
    chk("single_drained", 64'(bus_if.rsp_valid), 64'h0);

    // 3: all lanes continuously valid; pointer sits at 3 after lane 2
    for (int i = 0; i < N_REQ; i++) set_lane(i, 1'b1, 32'h1000 * (i + 1), 32'(i + 5));
    for (int j = 0; j < 8; j++) begin
      #1;
      chk("rr_req_ready", 64'(bus_if.req_ready), 64'(1) << seq_id[j]);
      exp_q.push_back('{id: seq_id[j], sum: lane_sum[seq_id[j]]});
      tick();
      chk("rr_back_to_back", 64'(bus_if.rsp_valid), 64'h1);
    end
    bus_if.req_valid = '0;
    chk("rr_grant_cnt", 64'(bus_if.grant_cnt), 64'd9);
    tick();

    // 4: backpressure with result 0x10 from lane 1
    bus_if.rsp_ready = 1'b0;
    set_lane(1, 1'b1, 32'h8, 32'h8);
    #1;
    chk("bp_first_grant", 64'(bus_if.req_ready), 64'h2);
    exp_q.push_back('{id: 2'd1, sum: 32'h10});
    tick();
    set_lane(1, 1'b0, 32'h0, 32'h0);
    set_lane(2, 1'b1, 32'h20, 32'h1);
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bp_req_ready", 64'(bus_if.req_ready), 64'h0);
      chk("bp_rsp_sum",   64'(bus_if.rsp_sum),   64'h10);
      chk("bp_rsp_id",    64'(bus_if.rsp_id),    64'h1);
      chk("bp_rsp_valid", 64'(bus_if.rsp_valid), 64'h1);
      tick();
    end
    bus_if.rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant", 64'(bus_if.req_ready), 64'h4);
    exp_q.push_back('{id: 2'd2, sum: 32'h21});
    tick();
    set_lane(2, 1'b0, 32'h0, 32'h0);
    chk("bp_refill_sum", 64'(bus_if.rsp_sum), 64'h21);
    tick();

    // 5: overflow on lane 3
    set_lane(3, 1'b1, 32'hFFFF_FFFF, 32'h2);
    exp_q.push_back('{id: 2'd3, sum: 32'h1});
    tick();
    set_lane(3, 1'b0, 32'h0, 32'h0);
    chk("ovf_grant_cnt", 64'(bus_if.grant_cnt), 64'd12);
    tick();

    // 6: reset while a result is held; rr_ptr would otherwise favour lane 1
    bus_if.rsp_ready = 1'b0;
    set_lane(0, 1'b1, 32'd1, 32'd1);
    exp_q.push_back('{id: 2'd0, sum: 32'd2});
    tick();
    chk("rst_mid_held", 64'(bus_if.rsp_valid), 64'h1);
    for (int i = 0; i < N_REQ; i++) set_lane(i, 1'b1, 32'(i + 1), 32'(i + 2));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_ready", 64'(bus_if.req_ready), 64'h0);
    dropped = exp_q.pop_back();
    tick();
    chk("rst_mid_dropped", 64'(bus_if.rsp_valid), 64'h0);
    chk("rst_mid_cnt_clr", 64'(bus_if.grant_cnt), 64'h0);
    rst_n = 1'b1;
    bus_if.rsp_ready = 1'b1;
    #1;
    chk("rst_mid_lane0", 64'(bus_if.req_ready), 64'h1);
    exp_q.push_back('{id: 2'd0, sum: 32'd3});
    tick();
    bus_if.req_valid = '0;
    chk("rst_mid_grant_cnt", 64'(bus_if.grant_cnt), 64'd1);
    tick();
    tick();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("final_idle", 64'(bus_if.rsp_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
